// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB slave-side bus bundle for ahb_sram_slave
// Purpose: groups the AHB address/control/data signals of one slave port.
// Macros: AHB_ADDR_BITS, AHB_DATA_BITS, AHB_RESP_BITS (defaults 32/32/2).
// Modports:
//   master - drives HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY;
//            observes HRDATA, HREADYOUT, HRESP
//   slave  - the mirror image
`ifndef AHB_ADDR_BITS
`define AHB_ADDR_BITS 32
`endif
`ifndef AHB_DATA_BITS
`define AHB_DATA_BITS 32
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif

interface ahb_sram_slave_if;
  logic                      HSEL;
  logic [`AHB_ADDR_BITS-1:0] HADDR;
  logic [1:0]                HTRANS;
  logic                      HWRITE;
  logic [2:0]                HSIZE;
  logic [`AHB_DATA_BITS-1:0] HWDATA;
  logic                      HREADY;
  logic [`AHB_DATA_BITS-1:0] HRDATA;
  logic                      HREADYOUT;
  logic [`AHB_RESP_BITS-1:0] HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB slave wrapping a word-organised register-file memory
// Purpose: pipelined AHB slave with byte/half/word writes, optional wait states
//          and a two-cycle ERROR response for illegal accesses.
// Optional feature macro: AHB_SRAM_WAIT_EN (adds WAIT_CYCLES wait states per
//          legal transfer; when undefined every legal transfer is zero-wait).
// Ports:
//   HCLK    - clock, all state on the rising edge
//   HRESETn - asynchronous active-low reset
//   bus     - ahb_sram_slave_if.slave (HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/
//             HREADY in, HRDATA/HREADYOUT/HRESP out)
`ifndef AHB_ADDR_BITS
`define AHB_ADDR_BITS 32
`endif
`ifndef AHB_DATA_BITS
`define AHB_DATA_BITS 32
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif

module ahb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_sram_slave_if.slave bus
);
  localparam int AW = `AHB_ADDR_BITS;
  localparam int DW = `AHB_DATA_BITS;
  localparam int RW = `AHB_RESP_BITS;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = DW / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t          state_q, state_d;
  logic            hreadyout_q, hreadyout_d;
  logic            hresp_q, hresp_d;
  logic            dphase_q, dphase_d;   // a legal data phase is outstanding
  logic [IW-1:0]   idx_q, idx_d;
  logic [NB-1:0]   lanes_q, lanes_d;
  logic            write_q, write_d;

`ifdef AHB_SRAM_WAIT_EN
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CW-1:0]   cnt_q, cnt_d;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  logic [DW-1:0]   mem [DEPTH];

  // Address-phase decode
  logic            accept;
  logic            size_err, align_err, range_err, xfer_err;
  logic [AW-1:0]   word_addr;
  logic [NB-1:0]   lanes_new;
  logic            complete;
  logic            unused_ok;

  assign unused_ok = bus.HTRANS[0];
  assign accept    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign word_addr = {2'b00, bus.HADDR[AW-1:2]};
  assign size_err  = bus.HSIZE > 3'd2;
  assign align_err = ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                     ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
  assign range_err = word_addr >= AW'(DEPTH);
  assign xfer_err  = size_err | align_err | range_err;

  always_comb begin
    lanes_new = '1;
    case (bus.HSIZE)
      3'd0:    lanes_new = NB'(1) << bus.HADDR[1:0];
      3'd1:    lanes_new = NB'(3) << {bus.HADDR[1], 1'b0};
      default: lanes_new = '1;
    endcase
  end

  // Data cycle finishes when a legal data phase is pending and we are ready.
  assign complete = dphase_q & hreadyout_q;

  always_comb begin
    state_d     = state_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    dphase_d    = dphase_q;
    idx_d       = idx_q;
    lanes_d     = lanes_q;
    write_d     = write_q;
`ifdef AHB_SRAM_WAIT_EN
    cnt_d       = cnt_q;
`endif
    if (complete) dphase_d = 1'b0;

    case (state_q)
      // ERR2 is the ready half of the error response, so a new address phase
      // is evaluated there exactly as in IDLE.
      ST_IDLE, ST_ERR2: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        if (accept) begin
          idx_d   = bus.HADDR[2 +: IW];
          lanes_d = lanes_new;
          write_d = bus.HWRITE;
          if (xfer_err) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
            dphase_d    = 1'b0;
          end else begin
            dphase_d = 1'b1;
`ifdef AHB_SRAM_WAIT_EN
            if (WAIT_CYCLES > 0) begin
              state_d     = ST_WAIT;
              hreadyout_d = 1'b0;
              cnt_d       = CW'(WAIT_CYCLES - 1);
            end
`endif
          end
        end
      end
`ifdef AHB_SRAM_WAIT_EN
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_IDLE;
          hreadyout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      dphase_q    <= 1'b0;
      idx_q       <= '0;
      lanes_q     <= '0;
      write_q     <= 1'b0;
`ifdef AHB_SRAM_WAIT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      dphase_q    <= dphase_d;
      idx_q       <= idx_d;
      lanes_q     <= lanes_d;
      write_q     <= write_d;
`ifdef AHB_SRAM_WAIT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Memory is not reset; a reset clears dphase_q, which drops any pending write.
  always_ff @(posedge HCLK) begin
    if (complete && write_q) begin
      for (int b = 0; b < NB; b++) begin
        if (lanes_q[b]) mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  // Read data is driven only in the completing cycle of a legal read; the
  // write of a preceding transfer has already committed by then.
  assign bus.HRDATA    = (complete && !write_q) ? mem[idx_q] : '0;
  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = RW'(hresp_q);

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - scoreboard testbench for ahb_sram_slave
module tb_ahb_sram_slave;
  localparam int DEPTH = 1024;
`ifdef AHB_SRAM_WAIT_EN
  localparam int WEXP = 2;
`else
  localparam int WEXP = 0;
`endif

  logic HCLK;
  logic HRESETn;
  ahb_sram_slave_if bus ();

  assign bus.HREADY = bus.HREADYOUT;

  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   dphase = 0;
  bit   err1   = 0;
  int   waits  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per data phase.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dphase = 0;
      chk("rst_ready", 32'(bus.HREADYOUT), 32'd1);
      chk("rst_resp",  32'(bus.HRESP),     32'd0);
      chk("rst_rdata", bus.HRDATA,         32'd0);
    end else begin
      if (dphase) begin
        if (!bus.HREADYOUT) begin
          if (bus.HRESP == 1) err1 = 1;
          else waits++;
          chk("stall_rdata", bus.HRDATA, 32'd0);
        end else begin
          exp_t e;
          dphase = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (e.err) begin
              chk("err_first", 32'(err1),       32'd1);
              chk("err_resp",  32'(bus.HRESP),  32'd1);
              chk("err_rdata", bus.HRDATA,      32'd0);
            end else begin
              chk("wait_cnt",  32'(waits),      32'(WEXP));
              chk("okay_resp", 32'(bus.HRESP),  32'd0);
              chk("rdata",     bus.HRDATA,      e.rd ? e.data : 32'd0);
            end
          end
        end
      end else begin
        chk("idle_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("idle_resp",  32'(bus.HRESP),     32'd0);
        chk("idle_rdata", bus.HRDATA,         32'd0);
      end
      if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
        dphase = 1;
        waits  = 0;
        err1   = 0;
      end
    end
  end

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input bit err, input logic [31:0] rexp);
    int n;
    exp_t e;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    n = 0;
    @(negedge HCLK);
    while (!bus.HREADY && n < 20) begin
      @(negedge HCLK);
      n++;
    end
    if (!bus.HREADY) begin
      chk("accept_timeout", 32'd1, 32'd0);
    end else begin
      e.err  = err;
      e.rd   = !wr;
      e.data = rexp;
      exp_q.push_back(e);
    end
    @(posedge HCLK);
    #1;
    bus.HWDATA = wdata;
  endtask

  task automatic idle(input int n, input bit sel);
    bus.HSEL   = sel;
    bus.HTRANS = 2'b00;
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  initial begin
    int n;
    HRESETn    = 1'b0;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b00;
    bus.HADDR  = '0;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'd2;
    bus.HWDATA = '0;
    repeat (2) @(posedge HCLK);
    #2;
    chk("reset_ready", 32'(bus.HREADYOUT), 32'd1);
    chk("reset_resp",  32'(bus.HRESP),     32'd0);
    chk("reset_rdata", bus.HRDATA,         32'd0);
    @(negedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    idle(4, 1'b1);

    // Back-to-back word write then read of the same word
    xfer(1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 0);
    xfer(0, 32'h10, 3'd2, 32'h0, 0, 32'hDEADBEEF);
    // Half write into upper lanes, byte write to lane 3
    xfer(1, 32'h12, 3'd1, 32'hCAFE0000, 0, 0);
    xfer(0, 32'h10, 3'd2, 32'h0, 0, 32'hCAFEBEEF);
    xfer(1, 32'h13, 3'd0, 32'h77000000, 0, 0);
    xfer(0, 32'h10, 3'd2, 32'h0, 0, 32'h77FEBEEF);
    idle(2, 1'b1);

    // Word, then byte and half merges; HSEL drops during a data phase
    xfer(1, 32'h20, 3'd2, 32'h11223344, 0, 0);
    idle(1, 1'b0);
    xfer(1, 32'h22, 3'd0, 32'h00AA0000, 0, 0);
    xfer(1, 32'h20, 3'd1, 32'h00005566, 0, 0);
    xfer(0, 32'h20, 3'd2, 32'h0, 0, 32'h11AA5566);

    // Misaligned half write, illegal size, out-of-range read
    xfer(1, 32'h21, 3'd1, 32'hFFFFFFFF, 1, 0);
    xfer(0, 32'h00, 3'd3, 32'h0, 1, 0);
    xfer(0, 32'h20, 3'd2, 32'h0, 0, 32'h11AA5566);
    xfer(0, 32'(DEPTH * 4), 3'd2, 32'h0, 1, 0);
    xfer(0, 32'h10, 3'd2, 32'h0, 0, 32'h77FEBEEF);
    idle(3, 1'b1);

    // Reset in the middle of a write data phase drops the write
    xfer(1, 32'h30, 3'd2, 32'h12345678, 0, 0);
    xfer(0, 32'h30, 3'd2, 32'h0, 0, 32'h12345678);
    idle(3, 1'b1);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = 32'h30;
    bus.HWRITE = 1'b1;
    bus.HSIZE  = 3'd2;
    @(posedge HCLK);
    #1;
    bus.HWDATA = 32'hFFFFFFFF;
    bus.HTRANS = 2'b00;
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_mid_resp",  32'(bus.HRESP),     32'd0);
    chk("rst_mid_rdata", bus.HRDATA,         32'd0);
    @(posedge HCLK);
    #3 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    xfer(0, 32'h30, 3'd2, 32'h0, 0, 32'h12345678);
    idle(4, 1'b1);

    n = 0;
    while ((exp_q.size() != 0 || dphase) && n < 20) begin
      @(posedge HCLK);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB slave wrapping a word-organised on-chip register-file memory. Its HRDATA/HREADYOUT/HRESP outputs drive one slave input triplet of the slave-to-master multiplexer (e.g. HRDATA_S1/HREADY_S1/HRESP_S1). Its HSEL comes from the address decoder. It handles pipelined address/data phases, byte/halfword/word writes, optional wait states, and a two-cycle ERROR response for illegal accesses.

## Interface
- DEPTH, 1024, number of `AHB_DATA_BITS`-wide words (power of two)
- WAIT_CYCLES, 2, wait states per transfer when `AHB_SRAM_WAIT_EN` is defined
- HCLK  in  1  clock, all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select from decoder
- HADDR  in  `AHB_ADDR_BITS`  byte address; index = HADDR[2+:$clog2(DEPTH)]
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = half, 2 = word, others illegal
- HWDATA  in  `AHB_DATA_BITS`  write data (data phase)
- HREADY  in  1  global HREADY fed back from the S2M mux
- HRDATA  out  `AHB_DATA_BITS`  read data
- HREADYOUT  out  1  this slave's ready
- HRESP  out  `AHB_RESP_BITS`  OKAY=0, ERROR=1

## Operation
- Address phase accepted when HSEL & HREADY & HTRANS[1]. On acceptance, register the word index, the byte offset HADDR[1:0], HWRITE, HSIZE and an error flag.
- IDLE/BUSY transfers and unselected transfers: no action. The slave returns zero-wait OKAY.
- Error if any of the following holds:
  - HSIZE > 2
  - misaligned: half with HADDR[0]=1, or word with HADDR[1:0]≠0
  - HADDR[`AHB_ADDR_BITS-1:2] ≥ DEPTH
- FSM states IDLE, WAIT, ERR1, ERR2:
  - IDLE: HREADYOUT=1, HRESP=OKAY. Accepted legal transfer → WAIT if waits are enabled and WAIT_CYCLES>0; otherwise the data phase completes in the next cycle while the state stays IDLE. Accepted illegal transfer → ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY. The counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At zero → IDLE, and that next cycle is the completing data cycle with HREADYOUT=1.
  - ERR1: HREADYOUT=0, HRESP=ERROR → ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR → IDLE. An address phase accepted in ERR2 is evaluated exactly as in IDLE.
- Write commits at the rising edge ending the completing data cycle, HREADYOUT=1. Lanes are little-endian:
  - byte: lane HADDR[1:0]
  - half: lanes {HADDR[1],0} and +1
  - word: all four lanes
  - Unwritten lanes are preserved. Errored transfers never write.
- Read: HRDATA = mem[index] in the completing data cycle of a legal read; HRDATA = 0 in every other cycle.
- Back-to-back write then read to the same word returns the new data, because the write commits before the read data cycle.

## Timing
- Reset values: HREADYOUT=1, HRESP=OKAY, HRDATA=0, state IDLE, counter 0, captured control cleared. Memory contents are not reset.
- Reset asserted mid-transfer: immediately return to reset values. A pending write is dropped.
- Zero-wait latency: address phase in cycle N, data and response in N+1.
- With waits: data completes in N+1+WAIT_CYCLES.
- ERROR response: exactly two cycles, starting in cycle N+1.
- A new address phase is accepted only in cycles where HREADY=1. Address and control are ignored while this slave stalls.
- HSEL deasserted during an outstanding data phase does not abort it.

## Configuration
- `AHB_SRAM_WAIT_EN` defined: WAIT state and counter are compiled in; every legal transfer inserts WAIT_CYCLES wait states. WAIT_CYCLES=0 behaves as zero-wait.
- Not defined: no WAIT state and no counter; every legal transfer completes zero-wait. WAIT_CYCLES is ignored.

## Test plan
- Reset, then idle bus (HTRANS=00, HSEL=1) → HREADYOUT=1, HRESP=0, HRDATA=0 every cycle.
- Word write 0xDEADBEEF to 0x10, then word read of 0x10 back-to-back → HRDATA=0xDEADBEEF in the read data cycle. With `AHB_SRAM_WAIT_EN` and WAIT_CYCLES=2 → exactly 2 cycles of HREADYOUT=0 per transfer.
- Word 0x11223344 at 0x20, then byte write 0xAA to 0x22 and half write 0x5566 to 0x20 → read returns 0x11AA5566.
- Half write at 0x21, then HSIZE=3 read at 0x0 → each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1. The word at 0x20 is unchanged.
- Read at DEPTH*4 → two-cycle ERROR, HRDATA=0.
- HRESETn pulsed low during the WAIT state of a write → outputs return to reset values and the target word is unchanged afterwards.
